// File: rtl/spi_seq_pkg.sv
`default_nettype none
//============================================================================
// Module      : spi_seq_pkg
// Description : Shared types and constants for the SPI register-burst
//               sequencer: FSM state encoding, engine R/W code and the
//               address/data/count widths.
// Ports       : none (package)
// Config      : none here; the watchdog option SPI_SEQ_WATCHDOG_EN is
//               consumed by spi_reg_sequencer.
// Revision    : 1.0 - initial release
//============================================================================
package spi_seq_pkg;

    localparam int SPI_ADDR_W  = 7;
    localparam int SPI_DATA_W  = 8;
    localparam int SEQ_COUNT_W = 4;

    // The engine reads when its R/W input is low.
    localparam logic SPI_RW_READ = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        PRESENT = 2'd3
    } seq_state_t;

endpackage : spi_seq_pkg
`default_nettype wire

// File: rtl/spi_seq_watchdog.sv
`default_nettype none
//============================================================================
// Module      : spi_seq_watchdog
// Description : 8-bit bounded-wait counter. Cleared while the sequencer is
//               about to enter WAIT, counts every WAIT cycle, and flags
//               expiry in the cycle that would bring it to TIMEOUT_CYCLES,
//               so the sequencer spends exactly TIMEOUT_CYCLES cycles in
//               WAIT before aborting.
// Ports       : clk      - sequencer clock
//               rst_n    - synchronous active-low reset
//               i_clear  - zero the counter (held during ISSUE)
//               i_enable - count this cycle (high during WAIT)
//               o_expire - last permitted WAIT cycle with no completion
// Revision    : 1.0 - initial release
//============================================================================
module spi_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [7:0] c_EXPIRE_VAL = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_clear) begin
            r_cnt <= 8'd0;
        end else if (i_enable && !o_expire) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_expire = i_enable && (r_cnt == c_EXPIRE_VAL);

endmodule : spi_seq_watchdog
`default_nettype wire

// File: rtl/spi_reg_sequencer.sv
`default_nettype none
//============================================================================
// Module      : spi_reg_sequencer
// Description : Runs a burst of reads of consecutive 7-bit register
//               addresses through the SPI register-read engine and presents
//               each {address, data} result on a valid/ready port. The next
//               read is only issued once the previous result is accepted.
// Ports       : FSM_Clk, RST_N (sync, active-low)
//               start, base_addr[6:0], count[3:0]  - burst request
//               spi_trigger, spi_addr[6:0], spi_rw - to engine
//               spi_done, spi_data[7:0]            - from engine
//               out_valid, out_ready, out_addr[6:0], out_data[7:0]
//               busy, seq_done, seq_error          - status
// Config      : `define SPI_SEQ_WATCHDOG_EN bounds WAIT to TIMEOUT_CYCLES
//               cycles and enables seq_error; otherwise WAIT is unbounded
//               and seq_error stays 0.
// Revision    : 1.0 - initial release
//============================================================================
module spi_reg_sequencer
    import spi_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  FSM_Clk,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic [SPI_ADDR_W-1:0] base_addr,
    input  logic [SEQ_COUNT_W-1:0] count,
    output logic                  spi_trigger,
    output logic [SPI_ADDR_W-1:0] spi_addr,
    output logic                  spi_rw,
    input  logic                  spi_done,
    input  logic [SPI_DATA_W-1:0] spi_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SPI_ADDR_W-1:0] out_addr,
    output logic [SPI_DATA_W-1:0] out_data,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  seq_error
);

    generate
        if ((TIMEOUT_CYCLES < 40) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
            $error("spi_reg_sequencer: TIMEOUT_CYCLES must be within 40..255");
        end
    endgenerate

    seq_state_t                 r_state, w_state_nxt;
    logic [SEQ_COUNT_W-1:0]     r_remaining, w_remaining_nxt;
    logic [SPI_ADDR_W-1:0]      r_spi_addr, w_spi_addr_nxt;
    logic [SPI_ADDR_W-1:0]      r_out_addr, w_out_addr_nxt;
    logic [SPI_DATA_W-1:0]      r_out_data, w_out_data_nxt;
    logic                       r_seq_done, w_seq_done_nxt;
    logic                       r_seq_error, w_seq_error_nxt;
    logic                       r_spi_trigger;
    logic                       r_out_valid;
    logic                       r_busy;
    logic                       w_wd_clear;
    logic                       w_wd_enable;
    logic                       w_wd_expire;

    assign w_wd_clear  = (r_state == ISSUE);
    assign w_wd_enable = (r_state == WAIT);

`ifdef SPI_SEQ_WATCHDOG_EN
    spi_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (FSM_Clk),
        .rst_n    (RST_N),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_expire (w_wd_expire)
    );
`else
    // Without the watchdog the error flag can never be set and is
    // reduced to a constant by synthesis.
    assign w_wd_expire = 1'b0 & w_wd_clear & w_wd_enable;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_spi_addr_nxt  = r_spi_addr;
        w_out_addr_nxt  = r_out_addr;
        w_out_data_nxt  = r_out_data;
        w_seq_done_nxt  = 1'b0;
        w_seq_error_nxt = r_seq_error;

        case (r_state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        w_spi_addr_nxt  = base_addr;
                        w_remaining_nxt = count;
                        w_seq_error_nxt = 1'b0;
                        w_state_nxt     = ISSUE;
                    end else begin
                        // Empty burst: report completion without touching the engine.
                        w_seq_done_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // A completion in the final permitted cycle still wins.
                if (spi_done) begin
                    w_out_data_nxt  = spi_data;
                    w_out_addr_nxt  = r_spi_addr;
                    w_remaining_nxt = r_remaining - 1'b1;
                    w_state_nxt     = PRESENT;
                end else if (w_wd_expire) begin
                    w_seq_error_nxt = 1'b1;
                    w_seq_done_nxt  = 1'b1;
                    w_state_nxt     = IDLE;
                end
            end
            PRESENT: begin
                if (r_out_valid && out_ready) begin
                    if (r_remaining == '0) begin
                        w_seq_done_nxt = 1'b1;
                        w_state_nxt    = IDLE;
                    end else begin
                        w_spi_addr_nxt = r_spi_addr + 1'b1;
                        w_state_nxt    = ISSUE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Status strobes are decoded from the next state so every output
    // comes straight from a flop.
    always_ff @(posedge FSM_Clk) begin
        if (!RST_N) begin
            r_state       <= IDLE;
            r_remaining   <= '0;
            r_spi_addr    <= '0;
            r_out_addr    <= '0;
            r_out_data    <= '0;
            r_seq_done    <= 1'b0;
            r_seq_error   <= 1'b0;
            r_spi_trigger <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_remaining   <= w_remaining_nxt;
            r_spi_addr    <= w_spi_addr_nxt;
            r_out_addr    <= w_out_addr_nxt;
            r_out_data    <= w_out_data_nxt;
            r_seq_done    <= w_seq_done_nxt;
            r_seq_error   <= w_seq_error_nxt;
            r_spi_trigger <= (w_state_nxt == ISSUE);
            r_out_valid   <= (w_state_nxt == PRESENT);
            r_busy        <= (w_state_nxt != IDLE);
        end
    end

    assign spi_trigger = r_spi_trigger;
    assign spi_addr    = r_spi_addr;
    assign spi_rw      = SPI_RW_READ;
    assign out_valid   = r_out_valid;
    assign out_addr    = r_out_addr;
    assign out_data    = r_out_data;
    assign busy        = r_busy;
    assign seq_done    = r_seq_done;
    assign seq_error   = r_seq_error;

endmodule : spi_reg_sequencer
`default_nettype wire

// File: tb/tb_spi_reg_sequencer.sv
`default_nettype none
//============================================================================
// Module      : tb_spi_reg_sequencer
// Description : Self-checking bench for spi_reg_sequencer with a 35-cycle
//               engine model returning 8'hA0 + address, and a queue of
//               expected {address, data} results.
// Config      : SPI_SEQ_WATCHDOG_EN adds the timeout scenario.
// Revision    : 1.0 - initial release
//============================================================================
module tb_spi_reg_sequencer;

    logic        FSM_Clk = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  base_addr = 7'd0;
    logic [3:0]  count = 4'd0;
    logic        spi_trigger;
    logic [6:0]  spi_addr;
    logic        spi_rw;
    logic        spi_done = 1'b0;
    logic [7:0]  spi_data = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [6:0]  out_addr;
    logic [7:0]  out_data;
    logic        busy;
    logic        seq_done;
    logic        seq_error;

    int          tests = 0;
    int          fails = 0;
    int          trig_total = 0;
    int          trig_wide = 0;
    bit          trig_prev = 1'b0;
    bit          eng_respond = 1'b1;
    logic [6:0]  eng_addr;
    logic [14:0] exp_q[$];

    spi_reg_sequencer #(.TIMEOUT_CYCLES(64)) dut (
        .FSM_Clk     (FSM_Clk),
        .RST_N       (RST_N),
        .start       (start),
        .base_addr   (base_addr),
        .count       (count),
        .spi_trigger (spi_trigger),
        .spi_addr    (spi_addr),
        .spi_rw      (spi_rw),
        .spi_done    (spi_done),
        .spi_data    (spi_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .busy        (busy),
        .seq_done    (seq_done),
        .seq_error   (seq_error)
    );

    always #5 FSM_Clk = ~FSM_Clk;

    // Engine model: done 35 cycles after the trigger cycle; no reset, so a
    // read in flight when the sequencer is reset still completes.
    always begin
        @(posedge FSM_Clk); #1;
        if (spi_trigger && eng_respond) begin
            eng_addr = spi_addr;
            repeat (35) @(posedge FSM_Clk);
            #1;
            spi_done = 1'b1;
            spi_data = 8'hA0 + {1'b0, eng_addr};
            @(posedge FSM_Clk); #1;
            spi_done = 1'b0;
            spi_data = 8'h00;
        end
    end

    // Trigger monitor: counts pulses and any pulse wider than one cycle.
    always begin
        @(posedge FSM_Clk); #1;
        if (spi_trigger) begin
            if (trig_prev) trig_wide++;
            else trig_total++;
        end
        trig_prev = spi_trigger;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge FSM_Clk); #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; start = 1'b0; out_ready = 1'b1;
        tick(); tick();
        tests++;
        if ({spi_trigger, spi_rw, out_valid, busy, seq_done, seq_error, spi_addr, out_addr, out_data} !== 28'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0000000",
                     {spi_trigger, spi_rw, out_valid, busy, seq_done, seq_error, spi_addr, out_addr, out_data});
        end
        RST_N = 1'b1;
        tick();
        tests++;
        if (busy !== 1'b0 || spi_trigger !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_idle: got busy=%b trig=%b expected 0/0", busy, spi_trigger);
        end
    endtask

    task automatic run_burst(input logic [6:0] base, input logic [3:0] cnt, input int stall, input string name);
        logic [6:0]  a;
        logic [14:0] exp;
        logic [14:0] held;
        int          trig_start;
        int          trig_before;
        int          budget;
        int          stall_left;
        bit          done_seen;
        bit          early_done;
        bit          stable;
        int          wide_start;

        exp_q.delete();
        for (int i = 0; i < int'(cnt); i++) begin
            a = base + 7'(i);
            exp_q.push_back({a, 8'hA0 + {1'b0, a}});
        end
        trig_start = trig_total;
        wide_start = trig_wide;
        stall_left = stall;
        out_ready  = (stall > 0) ? 1'b0 : 1'b1;
        budget     = 40 * int'(cnt) + stall + 20;
        done_seen  = 1'b0;
        early_done = 1'b0;

        start = 1'b1; base_addr = base; count = cnt;
        tick();
        start = 1'b0;
        tests++;
        if (spi_trigger !== 1'b1 || busy !== 1'b1 || seq_error !== 1'b0) begin
            fails++;
            $display("FAIL %s start_to_trigger: got trig=%b busy=%b err=%b expected 1/1/0",
                     name, spi_trigger, busy, seq_error);
        end

        while (!done_seen && budget > 0) begin
            if (out_valid && !out_ready && stall_left > 0) begin
                held = {out_addr, out_data};
                trig_before = trig_total;
                stable = 1'b1;
                for (int i = 0; i < stall_left; i++) begin
                    tick(); budget--;
                    if ({out_addr, out_data} !== held || out_valid !== 1'b1) stable = 1'b0;
                end
                tests++;
                if (!stable) begin
                    fails++;
                    $display("FAIL %s stall_stable: got %h expected held %h", name, {out_addr, out_data}, held);
                end
                tests++;
                if (trig_total != trig_before) begin
                    fails++;
                    $display("FAIL %s stall_no_trigger: got %0d triggers expected 0", name, trig_total - trig_before);
                end
                stall_left = 0;
                out_ready = 1'b1;
            end else if (out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL %s extra_result: got %h expected none", name, {out_addr, out_data});
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_addr, out_data} !== exp) begin
                        fails++;
                        $display("FAIL %s result: got addr=%h data=%h expected addr=%h data=%h",
                                 name, out_addr, out_data, exp[14:8], exp[7:0]);
                    end
                end
                tick(); budget--;
                tests++;
                if (exp_q.size() != 0) begin
                    if (spi_trigger !== 1'b1) begin
                        fails++;
                        $display("FAIL %s handshake_to_trigger: got %b expected 1", name, spi_trigger);
                    end
                end else begin
                    if (seq_done !== 1'b1 || busy !== 1'b0) begin
                        fails++;
                        $display("FAIL %s final_seq_done: got done=%b busy=%b expected 1/0", name, seq_done, busy);
                    end
                    done_seen = 1'b1;
                end
            end else begin
                if (seq_done) early_done = 1'b1;
                tick(); budget--;
            end
        end

        tests++;
        if (!done_seen) begin
            fails++;
            $display("FAIL %s burst_timeout: got %0d results left expected 0", name, exp_q.size());
        end
        tests++;
        if (early_done) begin
            fails++;
            $display("FAIL %s early_seq_done: got 1 expected 0", name);
        end
        tests++;
        if (trig_total - trig_start != int'(cnt) || trig_wide != wide_start) begin
            fails++;
            $display("FAIL %s trigger_count: got %0d (wide %0d) expected %0d (wide 0)",
                     name, trig_total - trig_start, trig_wide - wide_start, cnt);
        end
        tick();
        tests++;
        if (seq_done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s seq_done_width: got done=%b busy=%b expected 0/0", name, seq_done, busy);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_count_zero();
        int trig0;
        bit busy_seen;
        trig0 = trig_total;
        start = 1'b1; base_addr = 7'h33; count = 4'd0;
        tick();
        start = 1'b0;
        tests++;
        if (seq_done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL count_zero_done: got done=%b busy=%b expected 1/0", seq_done, busy);
        end
        busy_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy || seq_done) busy_seen = 1'b1;
        end
        tests++;
        if (busy_seen || trig_total != trig0) begin
            fails++;
            $display("FAIL count_zero_quiet: got busy/done=%b triggers=%0d expected 0/0", busy_seen, trig_total - trig0);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit activity;
        start = 1'b1; base_addr = 7'h20; count = 4'd2;
        tick();
        start = 1'b0;
        repeat (10) tick();
        RST_N = 1'b0;
        tick();
        tests++;
        if ({spi_trigger, spi_rw, out_valid, busy, seq_done, seq_error, spi_addr, out_addr, out_data} !== 28'd0) begin
            fails++;
            $display("FAIL mid_wait_reset: got %h expected 0000000",
                     {spi_trigger, spi_rw, out_valid, busy, seq_done, seq_error, spi_addr, out_addr, out_data});
        end
        tick();
        RST_N = 1'b1;
        // The orphaned engine read completes inside this window.
        activity = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy || out_valid || seq_done || spi_trigger || out_data !== 8'h00) activity = 1'b1;
        end
        tests++;
        if (activity) begin
            fails++;
            $display("FAIL stray_done_ignored: got activity=1 expected 0");
        end
        run_burst(7'h30, 4'd2, 0, "after_reset");
    endtask

`ifdef SPI_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        bit early;
        eng_respond = 1'b0;
        start = 1'b1; base_addr = 7'h05; count = 4'd2;
        tick();
        start = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (seq_done || !busy) early = 1'b1;
        end
        tests++;
        if (early) begin
            fails++;
            $display("FAIL wd_early_abort: got abort before 64 WAIT cycles expected none");
        end
        tick();
        tests++;
        if (seq_done !== 1'b1 || seq_error !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL wd_abort: got done=%b err=%b valid=%b busy=%b expected 1/1/0/0",
                     seq_done, seq_error, out_valid, busy);
        end
        tick();
        tests++;
        if (seq_error !== 1'b1 || seq_done !== 1'b0) begin
            fails++;
            $display("FAIL wd_error_sticky: got err=%b done=%b expected 1/0", seq_error, seq_done);
        end
        eng_respond = 1'b1;
        run_burst(7'h40, 4'd1, 0, "after_timeout");
    endtask
`endif

    initial begin
        test_reset();
        run_burst(7'h10, 4'd3, 0, "basic");
        run_burst(7'h7E, 4'd3, 0, "wrap");
        run_burst(7'h50, 4'd2, 20, "backpressure");
        test_count_zero();
        test_reset_mid_wait();
`ifdef SPI_SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_spi_reg_sequencer
`default_nettype wire

// File: doc/spi_reg_sequencer.md
# spi_reg_sequencer

Register-burst sequencer placed directly upstream of the SPI register-read engine. One `start` runs reads of `count` consecutive 7-bit sensor register addresses from `base_addr`. For each register it pulses the engine's trigger, waits for its `done`, captures the byte, and presents an {address, data} pair on a valid/ready output toward the host/FIFO side. Issue is stalled until the previous result is accepted.

## Interface
- `TIMEOUT_CYCLES`, default 64: FSM_Clk cycles allowed in WAIT before abort (watchdog builds only); range 40..255.
- `FSM_Clk` in, 1: sole clock; all logic on its rising edge.
- `RST_N` in, 1: synchronous, active-low reset.
- `start` in, 1: begin burst; sampled only in IDLE.
- `base_addr` in, 7: first register address; sampled with `start`.
- `count` in, 4: number of registers, 0..15; sampled with `start`.
- `spi_trigger` out, 1: to engine trigger; one-cycle pulse per read.
- `spi_addr` out, 7: to engine address; held stable from ISSUE through WAIT.
- `spi_rw` out, 1: to engine R/W; constant 0 (read).
- `spi_done` in, 1: engine completion pulse.
- `spi_data` in, 8: engine data out; valid in the cycle `spi_done`=1.
- `out_valid` out, 1: result available.
- `out_ready` in, 1: consumer accepts result.
- `out_addr` out, 7: address of presented byte.
- `out_data` out, 8: presented byte.
- `busy` out, 1: high in every state except IDLE.
- `seq_done` out, 1: one-cycle pulse at burst end (normal or abort).
- `seq_error` out, 1: sticky timeout flag; cleared by accepted `start` or reset.

## Operation
- States: IDLE, ISSUE, WAIT, PRESENT.
- IDLE: `start`=1 and `count`≠0: latch `base_addr` into `spi_addr`, `count` into `remaining`, clear `seq_error`, go ISSUE. `start`=1 and `count`=0: no transaction; `seq_done` pulses next cycle and the FSM stays in IDLE.
- ISSUE: `spi_trigger`=1 for exactly this cycle; go WAIT. The engine re-triggers if trigger is held, so the pulse is never longer than one cycle.
- WAIT: on `spi_done`, capture `spi_data`→`out_data`, `spi_addr`→`out_addr`, decrement `remaining`, go PRESENT.
- PRESENT: `out_valid`=1, with `out_addr`/`out_data` stable until the handshake. On `out_valid && out_ready`:
  - `remaining`=0: go IDLE and pulse `seq_done`.
  - otherwise: `spi_addr` ← `spi_addr`+1 (7-bit wrap, 7'h7F→7'h00), go ISSUE.
- `start` outside IDLE is ignored. `spi_done` outside WAIT is ignored. This covers a late completion from an engine transaction orphaned by reset, because the engine has no reset.
- Reset in any state: state=IDLE. `spi_trigger`, `out_valid`, `busy`, `seq_done`, `seq_error` all =0; `spi_addr`, `out_addr`=0; `out_data`=0; `spi_rw`=0.

## Timing
- `start` (cycle N) → `spi_trigger` high in cycle N+1.
- `spi_done` (cycle M) → `out_valid` high in cycle M+1.
- Handshake (cycle K) → next `spi_trigger` in cycle K+1. If this was the last read, `seq_done` and `busy`=0 appear in cycle K+1.
- Engine transaction is 35 cycles from trigger to done. With `out_ready` tied high, each register takes 37 cycles.
- All outputs are registered; no combinational input→output paths.

## Configuration
- `SPI_SEQ_WATCHDOG_EN` defined: an 8-bit counter clears on entering WAIT and increments each WAIT cycle. When it reaches `TIMEOUT_CYCLES` without `spi_done`, the FSM goes IDLE, sets `seq_error`=1, pulses `seq_done`, and leaves `out_valid`=0.
- Not defined: WAIT has no bound, and `seq_error` is constant 0.

## Structure
- Package `spi_seq_pkg` holds:
  - state encoding (enum, 2 bits);
  - `SPI_RW_READ` = 1'b0;
  - `SPI_ADDR_W`=7, `SPI_DATA_W`=8, `SEQ_COUNT_W`=4.
- One natural sub-module, `spi_seq_watchdog`: clear/enable/expire counter, instantiated only under `SPI_SEQ_WATCHDOG_EN`.

## Test plan
- `base_addr`=7'h10, `count`=3, engine model returns 8'hA0+addr_low, `out_ready`=1:
  - outputs (10,B0), (11,B1), (12,B2);
  - exactly 3 single-cycle trigger pulses;
  - `seq_done` one cycle after the third handshake.
- `base_addr`=7'h7E, `count`=3 → addresses 7E, 7F, 00 (wrap).
- `out_ready` held 0 for 20 cycles in PRESENT: `out_data`/`out_addr` stable, no `spi_trigger`; release → next trigger one cycle after handshake.
- `count`=0 → no `spi_trigger`, `seq_done` one cycle after `start`, `busy` stays 0.
- Watchdog build: model never asserts done → abort after 64 WAIT cycles, with `seq_error`=1, `seq_done` pulse, `out_valid`=0. A fresh `start` clears `seq_error`.
- `RST_N`=0 mid-WAIT, then a stray `spi_done` after reset: all outputs at reset values, stray done ignored, a subsequent burst is correct.
